// File: rtl/ofifo.sv
// ofifo: per-column circular FIFOs collecting array psums (in/wr per column), popped as whole rows (rd -> out, o_valid/o_full/o_ready/overflow flags)
module ofifo #(
  parameter int col     = 8,
  parameter int psum_bw = 16,
  parameter int depth   = 8,
  parameter int ptr_bw  = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [col*psum_bw-1:0] in,
  input  logic [col-1:0]         wr,
  input  logic                   rd,
  output logic [col*psum_bw-1:0] out,
  output logic                   o_valid,
  output logic                   o_full,
  output logic                   o_ready,
  output logic                   overflow
);
  logic [col-1:0] empty, full;
  logic pop;
  assign pop = rd & o_valid;
  assign o_valid = ~|empty;
  assign o_full = |full;
  assign o_ready = ~o_full;
  for (genvar c = 0; c < col; c++) begin : g_col
    logic [psum_bw-1:0] mem [depth];
    logic [ptr_bw:0] wptr, rptr;
    assign empty[c] = wptr == rptr;
    assign full[c] = wptr == {~rptr[ptr_bw], rptr[ptr_bw-1:0]};
    assign out[c*psum_bw +: psum_bw] = mem[rptr[ptr_bw-1:0]];
    always_ff @(posedge clk or posedge reset)
      if (reset) begin
        wptr <= '0;
        rptr <= '0;
        for (int k = 0; k < depth; k++) mem[k] <= '0;
      end else begin
        if (wr[c] && (!full[c] || pop)) begin
          mem[wptr[ptr_bw-1:0]] <= in[c*psum_bw +: psum_bw];
          wptr <= wptr + 1'b1;
        end
        if (pop) rptr <= rptr + 1'b1;
      end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) overflow <= 1'b0;
    else overflow <= overflow | (|(wr & full & {col{~pop}}));
endmodule

// File: tb/tb_ofifo.sv
// tb_ofifo: randomized scoreboard bench for ofifo against a queue-based row model
module tb_ofifo;
  localparam int COL = 8, BW = 16, DEPTH = 8;
  logic clk = 0, reset = 1, rd = 0;
  logic [COL*BW-1:0] in = '0, out;
  logic [COL-1:0] wr = '0;
  logic o_valid, o_full, o_ready, overflow;
  int vecs = 0, errs = 0;
  logic [BW-1:0] q [COL][$];
  logic [COL*BW-1:0] exp_q [$];
  logic m_ovf = 0;

  ofifo #(.col(COL), .psum_bw(BW), .depth(DEPTH), .ptr_bw(3)) dut (
    .clk(clk), .reset(reset), .in(in), .wr(wr), .rd(rd), .out(out),
    .o_valid(o_valid), .o_full(o_full), .o_ready(o_ready), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic bit m_valid();
    for (int c = 0; c < COL; c++) if (q[c].size() == 0) return 0;
    return 1;
  endfunction

  function automatic bit m_full();
    for (int c = 0; c < COL; c++) if (q[c].size() == DEPTH) return 1;
    return 0;
  endfunction

  task automatic chk_flags(input string name);
    logic [3:0] exp_f;
    exp_f = {m_valid(), m_full(), !m_full(), m_ovf};
    vecs++;
    if ({o_valid, o_full, o_ready, overflow} !== exp_f) begin
      errs++;
      $display("FAIL %s flags{valid,full,ready,ovf} got %b want %b", name,
               {o_valid, o_full, o_ready, overflow}, exp_f);
    end
  endtask

  task automatic step(input logic [COL-1:0] w, input logic [COL*BW-1:0] d, input logic r, input string name);
    logic [COL*BW-1:0] row;
    bit p;
    @(posedge clk); #1;
    chk_flags(name);
    wr = w; in = d; rd = r;
    p = r && m_valid();
    if (p) begin
      for (int c = 0; c < COL; c++) row[c*BW +: BW] = q[c][0];
      exp_q.push_back(row);
      for (int c = 0; c < COL; c++) void'(q[c].pop_front());
    end
    for (int c = 0; c < COL; c++)
      if (w[c]) begin
        if (q[c].size() < DEPTH) q[c].push_back(d[c*BW +: BW]);
        else m_ovf = 1;
      end
  endtask

  task automatic do_reset(input string name);
    @(posedge clk); #3;
    wr = '0; rd = 0;
    reset = 1;
    #1;
    for (int c = 0; c < COL; c++) q[c].delete();
    exp_q.delete();
    m_ovf = 0;
    chk_flags(name);
    vecs++;
    if (out !== '0) begin
      errs++;
      $display("FAIL %s out got %h want 0", name, out);
    end
    @(posedge clk); #3;
    reset = 0;
  endtask

  function automatic logic [COL*BW-1:0] row_val(input int r);
    logic [COL*BW-1:0] v;
    for (int c = 0; c < COL; c++) v[c*BW +: BW] = BW'(r * 16 + c);
    return v;
  endfunction

  always @(negedge clk)
    if (!reset && rd && o_valid) begin
      vecs++;
      if (exp_q.size() == 0) begin
        errs++;
        $display("FAIL pop unexpected pop, out %h, no row expected", out);
      end else begin
        logic [COL*BW-1:0] e;
        e = exp_q.pop_front();
        if (out !== e) begin
          errs++;
          $display("FAIL pop row got %h want %h", out, e);
        end
      end
    end

  initial begin
    logic [COL*BW-1:0] d;
    do_reset("reset");
    step('0, '0, 0, "idle");
    for (int i = 0; i < COL; i++) begin
      d = '0;
      d[i*BW +: BW] = BW'(16'h0100 + i);
      step(COL'(1) << i, d, 0, "stagger");
    end
    step('0, '0, 1, "stagger_rd");
    step('0, '0, 0, "stagger_empty");
    for (int r = 0; r < DEPTH; r++) step('1, row_val(r), 0, "fill");
    step('0, '0, 0, "full");
    step('1, row_val(8), 1, "full_wr_rd");
    step('0, '0, 0, "full_after_wr_rd");
    step('1, row_val(9), 0, "drop");
    step('0, '0, 0, "overflow");
    for (int r = 0; r < DEPTH; r++) step('0, '0, 1, "drain");
    step('0, '0, 0, "drained");
    do_reset("reset2");
    for (int r = 0; r < 20; r++) step('1, row_val(r + 32), r > 0, "wrap");
    step('0, '0, 1, "wrap_last");
    step('0, '0, 0, "wrap_done");
    for (int n = 0; n < 400; n++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      step(COL'($urandom), d, 1'($urandom_range(0, 2) == 0 ? 0 : 1) & 1'($urandom), "random");
    end
    step('0, '0, 0, "random_end");
    do_reset("reset3");
    for (int r = 0; r < 3; r++) step('1, row_val(r + 64), 0, "pre_reset");
    step('0, '0, 0, "pre_reset_idle");
    do_reset("mid_reset");
    for (int i = 0; i < COL; i++) begin
      d = '0;
      d[i*BW +: BW] = BW'(16'h0200 + i);
      step(COL'(1) << i, d, 0, "cold_fill");
    end
    step('0, '0, 1, "cold_rd");
    step('0, '0, 0, "cold_done");
    vecs++;
    if (exp_q.size() != 0) begin
      errs++;
      $display("FAIL leftover rows got %0d want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ofifo.md
Name: ofifo

Overview:
- Output collector at the south edge of the systolic MAC array.
- Accepts per-column partial sums from the bottom MAC row, each column's `psum_bw` slice qualified by its own `wr` bit (driven by the row's per-column valid output).
- Columns fire on staggered cycles, so each column is buffered in an independent circular FIFO.
- A full output row is presented to the downstream reader (SRAM writeback / accumulator) only when every column holds at least one entry; a single `rd` pops all columns together.

Parameters:
- `col`, 8, number of array columns (independent column FIFOs).
- `psum_bw`, 16, width of one partial sum.
- `depth`, 8, entries per column FIFO; power of 2, ≥ 2.
- `ptr_bw`, 3, log2(`depth`); address width; pointers are `ptr_bw`+1 bits.

Ports:
- `clk` input 1: clock, rising-edge.
- `reset` input 1: asynchronous, active-high reset.
- `in` input `col*psum_bw`: column psums; column i occupies bits [`psum_bw`*(i+1)-1 : `psum_bw`*i].
- `wr` input `col`: per-column write strobe; bit i qualifies column i of `in`.
- `rd` input 1: pop one entry from every column.
- `out` output `col*psum_bw`: head entry of each column (show-ahead); same packing as `in`.
- `o_valid` output 1: all columns non-empty; `out` is a complete row.
- `o_full` output 1: at least one column FIFO is full.
- `o_ready` output 1: no column FIFO is full; the array may issue execute.
- `overflow` output 1: sticky error flag; a write was dropped.

Behaviour:
- **Reset** (asynchronous, active-high): applies immediately, independent of `clk`, including mid-operation. All read/write pointers = 0; storage cleared to 0; `out`=0, `o_valid`=0, `o_full`=0, `o_ready`=1, `overflow`=0.
- **Per-column state:**
  - `wptr_i`, `rptr_i`, each `ptr_bw`+1 bits, wrapping modulo 2*`depth`.
  - `count_i` = `wptr_i` − `rptr_i`.
  - `empty_i` when pointers are equal.
  - `full_i` when the low `ptr_bw` bits are equal and the MSBs differ.
- **Pop:** `pop` = `rd` & `o_valid`. `rd` while `o_valid`=0 is ignored; no pointer moves and no error is flagged.
- **Write, column i** (rising edge, `wr[i]`=1):
  - Accepted if !`full_i`, or if `full_i` and `pop`=1 in the same cycle.
  - Data goes to `mem_i[wptr_i[ptr_bw-1:0]]`; `wptr_i` increments.
  - Otherwise the write is dropped, storage is unchanged, and `overflow` sets and holds until reset.
- **Read:** when `pop`=1, every `rptr_i` increments on the same edge.
- **Simultaneous write and pop on one column:** both occur; `count_i` is unchanged.
- **Write into an empty column:** visible on `out` and counted toward `o_valid` the cycle after the edge. Latency from `wr` to `out`/`o_valid` is 1 cycle; there is no write-through bypass.
- **`out` slice i:** `mem_i[rptr_i[ptr_bw-1:0]]`, combinational from registered state. Its value is meaningless when `o_valid`=0.
- **Flags:** `o_valid` = AND of !`empty_i`; `o_full` = OR of `full_i`; `o_ready` = !`o_full`. All are combinational from registered pointers, so there are no glitches between edges.
- **Wrap-around:** after `depth` writes/pops the address wraps to 0. MSB toggling keeps full and empty distinct.
- **Column independence:** columns fill independently; skew of up to `depth`−1 entries between columns is tolerated.

Test Plan:
- Reset, then idle → `out`=0, `o_valid`=0, `o_ready`=1, `o_full`=0, `overflow`=0.
- Staggered fill: `wr[i]` asserted on cycle i with `in` slice i = 16'h0100+i, for i=0..7 → `o_valid` stays 0 until the edge after column 7 writes. `out` = {16'h0107 … 16'h0100}. `rd`=1 for one cycle → `o_valid`=0.
- Fill all columns with 8 rows (values row*16+col) → `o_full`=1, `o_ready`=0. A 9th write with `rd`=0 → dropped, `overflow`=1. Reads return rows 0..7 in order.
- Full FIFO, `wr`=8'hFF and `rd`=1 on the same edge → write accepted, count stays 8, `overflow` stays 0. The next `out` is row 1.
- Wrap: 20 rows written and read in lockstep (1-row lag) → every popped row matches the value written; `o_full` never asserts.
- Assert `reset` mid-stream (3 rows buffered, between clock edges) → flags and `out` return to reset values immediately, without waiting for a clock edge. Subsequent fill behaves as from cold.
